// File: rtl/uart_cmd_bridge_if.sv
// Byte-level UART handshake plus the 8-bit/16-bit-address register bus,
// bundled so the bridge and its neighbours share one connection.
// master: the command bridge. slave: the UART and bus side.
interface uart_cmd_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_clr;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;

  modport master (
    input  rx_data, rx_valid, tx_busy, bus_rdata, bus_ack,
    output rx_clr, tx_data, tx_start, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, bus_rdata, bus_ack,
    input  rx_clr, tx_data, tx_start, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: parses 'W' addr_hi addr_lo data / 'R' addr_hi addr_lo len
// from the UART receive side, runs the bus accesses and streams replies back.
// Optional macro CMD_TIMEOUT_EN: abandon a half-received command after
// 2^TIMEOUT_W-1 idle cycles between argument bytes.
module uart_cmd_bridge #(
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_bridge_if.master bif,
  output logic              o_active
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, ARG, BUS, SEND, TX_WAIT} state_t;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  state_t      r_state, w_state_nxt;
  logic        r_rx_clr, r_tx_start, r_bus_req, r_bus_we;
  logic [7:0]  r_tx_data, r_bus_wdata, r_cnt;
  logic [15:0] r_bus_addr;
  logic [1:0]  r_guard;

  logic w_take, w_consume, w_cmd_ok, w_ack, w_tx_done, w_more, w_tmo;

  // A byte is only taken when the UART's clear from the previous take has landed.
  assign w_take    = bif.rx_valid & ~r_rx_clr;
  assign w_cmd_ok  = (bif.rx_data == CMD_W) || (bif.rx_data == CMD_R);
  assign w_ack     = bif.bus_ack & r_bus_req;
  assign w_tx_done = (r_guard == 2'd0) & ~bif.tx_busy;
  assign w_more    = ~r_bus_we & (r_cnt != 8'd0);

`ifdef CMD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo;
  logic                 w_parse;

  assign w_parse = (r_state == ADDR_HI) || (r_state == ADDR_LO) || (r_state == ARG);
  assign w_tmo   = w_parse && (r_tmo == '1);

  // Inter-byte watchdog: runs only while waiting for argument bytes, saturates.
  always_ff @(posedge clk) begin
    if (rst)                       r_tmo <= '0;
    else if (!w_parse || w_consume) r_tmo <= '0;
    else if (!w_tmo)               r_tmo <= r_tmo + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and byte-consume decision.
  always_comb begin
    w_state_nxt = r_state;
    w_consume   = 1'b0;
    case (r_state)
      IDLE:    if (w_take) begin
                 w_consume   = 1'b1;
                 w_state_nxt = w_cmd_ok ? ADDR_HI : SEND;
               end
      ADDR_HI: if (w_take) begin w_consume = 1'b1; w_state_nxt = ADDR_LO; end
               else if (w_tmo) w_state_nxt = IDLE;
      ADDR_LO: if (w_take) begin w_consume = 1'b1; w_state_nxt = ARG; end
               else if (w_tmo) w_state_nxt = IDLE;
      ARG:     if (w_take) begin w_consume = 1'b1; w_state_nxt = BUS; end
               else if (w_tmo) w_state_nxt = IDLE;
      BUS:     if (w_ack) w_state_nxt = SEND;
      SEND:    w_state_nxt = TX_WAIT;
      TX_WAIT: if (w_tx_done) w_state_nxt = w_more ? BUS : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: argument capture, bus request, reply byte and busy guard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_clr    <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'd0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 16'd0;
      r_bus_wdata <= 8'd0;
      r_cnt       <= 8'd0;
      r_guard     <= 2'd0;
    end else begin
      r_rx_clr   <= w_consume;
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE:    if (w_consume) begin
                   if (w_cmd_ok) r_bus_we <= (bif.rx_data == CMD_W);
                   else begin r_tx_data <= NAK; r_tx_start <= 1'b1; end
                 end
        ADDR_HI: if (w_consume) r_bus_addr[15:8] <= bif.rx_data;
        ADDR_LO: if (w_consume) r_bus_addr[7:0]  <= bif.rx_data;
        ARG:     if (w_consume) begin
                   if (r_bus_we) r_bus_wdata <= bif.rx_data;
                   else          r_cnt       <= bif.rx_data;
                   r_bus_req <= 1'b1;
                 end
        BUS:     if (w_ack) begin
                   r_bus_req  <= 1'b0;
                   r_tx_data  <= r_bus_we ? ACK : bif.bus_rdata;
                   r_tx_start <= 1'b1;
                 end
        // The UART reports busy two cycles late; mask it that long.
        SEND:    r_guard <= 2'd2;
        TX_WAIT: if (r_guard != 2'd0) r_guard <= r_guard - 2'd1;
                 else if (!bif.tx_busy && w_more) begin
                   r_cnt      <= r_cnt - 8'd1;
                   r_bus_addr <= r_bus_addr + 16'd1;
                   r_bus_req  <= 1'b1;
                 end
        default: ;
      endcase
    end
  end

  assign bif.rx_clr    = r_rx_clr;
  assign bif.tx_start  = r_tx_start;
  assign bif.tx_data   = r_tx_data;
  assign bif.bus_req   = r_bus_req;
  assign bif.bus_we    = r_bus_we;
  assign bif.bus_addr  = r_bus_addr;
  assign bif.bus_wdata = r_bus_wdata;
  assign o_active      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench for uart_cmd_bridge: a protocol-level reference model
// pushes expected bus accesses and reply bytes; UART/bus responder processes
// pop and compare whenever the DUT presents a request or a transmit.
module tb_uart_cmd_bridge;
`ifdef CMD_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 20;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic active;

  uart_cmd_bridge_if bif();

  uart_cmd_bridge #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .bif(bif), .o_active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_op_t;

  bus_op_t    exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] slv_mem [logic [15:0]];

  int n_cmp = 0, n_err = 0;
  int n_rx_sent = 0, n_rx_clr = 0, n_tx_seen = 0, n_bus_seen = 0;
  bit abort_ok = 1'b0;

  function automatic logic [7:0] mem_init(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [7:0] slv_rd(input logic [15:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : mem_init(a);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Protocol-level model: what a command should do on the bus and the wire.
  task automatic model_cmd(input logic [7:0] c, input logic [7:0] hi,
                           input logic [7:0] lo, input logic [7:0] arg);
    logic [15:0] a, ai;
    bus_op_t     op;
    a = {hi, lo};
    if (c == 8'h57) begin
      op.we = 1'b1; op.addr = a; op.wdata = arg;
      exp_bus.push_back(op);
      exp_tx.push_back(8'h06);
      ref_mem[a] = arg;
    end else if (c == 8'h52) begin
      for (int i = 0; i <= int'(arg); i++) begin
        ai = a + 16'(i);
        op.we = 1'b0; op.addr = ai; op.wdata = 8'h00;
        exp_bus.push_back(op);
        exp_tx.push_back(ref_rd(ai));
      end
    end else begin
      exp_tx.push_back(8'h15);
    end
  endtask

  // Host side of the UART receiver: present a byte, hold until cleared.
  task automatic send_byte(input logic [7:0] b);
    int t;
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    n_rx_sent++;
    t = 0;
    while (t < 5000) begin
      @(negedge clk);
      if (bif.rx_clr) break;
      t++;
    end
    if (t >= 5000) fail("rx_consume_timeout");
    @(posedge clk);
    #1 bif.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 20000) begin
      @(negedge clk);
      if (!active && exp_tx.size() == 0 && exp_bus.size() == 0 && !bif.tx_busy) break;
      t++;
    end
    if (t >= 20000) begin
      fail("response_timeout");
      exp_tx.delete();
      exp_bus.delete();
    end
  endtask

  task automatic run_cmd(input logic [7:0] c, input logic [7:0] hi,
                         input logic [7:0] lo, input logic [7:0] arg);
    model_cmd(c, hi, lo, arg);
    send_byte(c);
    if (c == 8'h57 || c == 8'h52) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(hi);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(lo);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(arg);
    end
    wait_idle();
  endtask

  // UART transmitter: busy rises shortly after tx_start, lasts one "frame".
  initial begin
    bif.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.tx_start) begin
        @(posedge clk);
        #1 bif.tx_busy = 1'b1;
        repeat ($urandom_range(4, 14)) @(posedge clk);
        #1 bif.tx_busy = 1'b0;
      end
    end
  end

  // Transmit / rx_clr monitor.
  initial begin
    bit prev_clr;
    prev_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.tx_start) begin
        chk("tx_start_while_busy", int'(bif.tx_busy), 0);
        if (exp_tx.size() == 0) fail("unexpected_tx_start");
        else chk("tx_data", int'(bif.tx_data), int'(exp_tx.pop_front()));
        n_tx_seen++;
      end
      if (bif.rx_clr) begin
        n_rx_clr++;
        if (prev_clr) fail("rx_clr_width");
      end
      prev_clr = bif.rx_clr;
    end
  end

  // Bus responder: checks each request against the scoreboard, random ack delay,
  // random spurious acks while idle.
  initial begin
    bus_op_t op, e;
    bit      ab;
    int      d;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bif.bus_req && !rst) begin
        op.we = bif.bus_we; op.addr = bif.bus_addr; op.wdata = bif.bus_wdata;
        n_bus_seen++;
        if (exp_bus.size() == 0) fail("unexpected_bus_req");
        else begin
          e = exp_bus.pop_front();
          chk("bus_we", int'(op.we), int'(e.we));
          chk("bus_addr", int'(op.addr), int'(e.addr));
          if (e.we) chk("bus_wdata", int'(op.wdata), int'(e.wdata));
        end
        d  = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, 4);
        ab = 1'b0;
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (!bif.bus_req) begin ab = 1'b1; break; end
          chk("bus_stable", int'({bif.bus_we, bif.bus_addr, bif.bus_wdata}),
              int'({op.we, op.addr, op.wdata}));
        end
        if (ab) begin
          if (!abort_ok) fail("bus_req_dropped_early");
        end else begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = op.we ? 8'($urandom) : slv_rd(op.addr);
          if (op.we) slv_mem[op.addr] = op.wdata;
          @(negedge clk);
          bif.bus_ack   = 1'b0;
          bif.bus_rdata = 8'($urandom);
          if (!abort_ok) begin
            chk("bus_req_after_ack", int'(bif.bus_req), 0);
            chk("tx_start_after_ack", int'(bif.tx_start), 1);
          end
        end
      end else if (!rst && $urandom_range(0, 7) == 0) begin
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 8'($urandom);
        @(negedge clk);
        bif.bus_ack = 1'b0;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_clr"},    int'(bif.rx_clr), 0);
    chk({tag, "_tx_start"},  int'(bif.tx_start), 0);
    chk({tag, "_tx_data"},   int'(bif.tx_data), 0);
    chk({tag, "_bus_req"},   int'(bif.bus_req), 0);
    chk({tag, "_bus_we"},    int'(bif.bus_we), 0);
    chk({tag, "_bus_addr"},  int'(bif.bus_addr), 0);
    chk({tag, "_bus_wdata"}, int'(bif.bus_wdata), 0);
    chk({tag, "_active"},    int'(active), 0);
  endtask

  initial begin
    int          nb, t, tx0;
    logic [7:0]  c, hi, lo, arg;
    bif.rx_data  = 8'h00;
    bif.rx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed write.
    run_cmd(8'h57, 8'h12, 8'h34, 8'hA5);
    chk("mem_1234", int'(slv_rd(16'h1234)), 8'hA5);

    // Read burst wrapping through 0xFFFF.
    ref_mem[16'hFFFE] = 8'h11; slv_mem[16'hFFFE] = 8'h11;
    ref_mem[16'hFFFF] = 8'h22; slv_mem[16'hFFFF] = 8'h22;
    ref_mem[16'h0000] = 8'h33; slv_mem[16'h0000] = 8'h33;
    run_cmd(8'h52, 8'hFF, 8'hFE, 8'h02);

    // Unknown command: NAK only, then a normal read.
    nb = n_bus_seen;
    run_cmd(8'h41, 8'h00, 8'h00, 8'h00);
    chk("nak_no_bus", n_bus_seen - nb, 0);
    run_cmd(8'h52, 8'h00, 8'h00, 8'h00);

    // Random mix, addresses clustered so reads revisit writes.
    for (int i = 0; i < 40; i++) begin
      t   = $urandom_range(0, 9);
      hi  = 8'($urandom_range(0, 1));
      lo  = 8'($urandom);
      arg = 8'($urandom);
      if (t < 4)      c = 8'h57;
      else if (t < 8) begin c = 8'h52; arg = 8'($urandom_range(0, 5)); end
      else begin
        c = 8'($urandom);
        if (c == 8'h57 || c == 8'h52) c = 8'h00;
      end
      run_cmd(c, hi, lo, arg);
    end

    // Maximum length: 256 bytes.
    run_cmd(8'h52, 8'h01, 8'($urandom), 8'hFF);

    // Reset while a burst is mid-flight.
    model_cmd(8'h52, 8'h00, 8'h40, 8'h05);
    tx0 = n_tx_seen;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h40); send_byte(8'h05);
    t = 0;
    while (t < 20000) begin
      @(negedge clk);
      if (n_tx_seen - tx0 >= 2 && bif.bus_req) break;
      t++;
    end
    if (t >= 20000) fail("burst_reset_setup_timeout");
    #2;
    abort_ok = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    exp_tx.delete();
    exp_bus.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    wait_idle();
    abort_ok = 1'b0;
    run_cmd(8'h57, 8'h00, 8'h02, 8'hC3);
    chk("mem_0002", int'(slv_rd(16'h0002)), 8'hC3);

`ifdef CMD_TIMEOUT_EN
    // Half a command, then silence: block must give up without a reply.
    nb = n_bus_seen;
    send_byte(8'h57);
    send_byte(8'h12);
    repeat (20) @(negedge clk);
    chk("timeout_idle", int'(active), 0);
    chk("timeout_no_bus", n_bus_seen - nb, 0);
    run_cmd(8'h57, 8'h00, 8'h01, 8'h5A);
    chk("mem_0001", int'(slv_rd(16'h0001)), 8'h5A);
`endif

    chk("rx_clr_count", n_rx_clr, n_rx_sent);
    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_bus_drained", exp_bus.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
